// File: rtl/pc_fetch.sv
// Instruction fetch front end: holds the PC and issues one memory request at a time.
// It presents each fetched instruction to decode and squashes responses made stale by a redirect.
module pc_fetch #(
   parameter int unsigned                ADDRESS_WIDTH = 8,
   parameter int unsigned                DATA_WIDTH    = 32,
   parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDRESS_WIDTH-1:0] next_pc,
   input  logic                     redirect,
   output logic [ADDRESS_WIDTH-1:0] pc,
   output logic                     imem_req,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic                     imem_gnt,
   input  logic                     imem_rvalid,
   input  logic [DATA_WIDTH-1:0]    imem_rdata,
   output logic                     instr_valid,
   output logic [DATA_WIDTH-1:0]    instr,
   output logic [ADDRESS_WIDTH-1:0] instr_pc,
   input  logic                     instr_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      OUT  = 2'd3
   } state_e;

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
   logic                     squash_q, squash_d;
   logic                     instr_valid_q, instr_valid_d;
   logic [DATA_WIDTH-1:0]    instr_q, instr_d;
   logic [ADDRESS_WIDTH-1:0] instr_pc_q, instr_pc_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         squash_q      <= 1'b0;
         instr_valid_q <= 1'b0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         squash_q      <= squash_d;
         instr_valid_q <= instr_valid_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      squash_d      = squash_q;
      instr_valid_d = instr_valid_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;

      unique case (state_q)
         IDLE: begin
            state_d = REQ;
         end

         REQ: begin
            if (redirect) begin
               pc_d          = next_pc;
               instr_valid_d = 1'b0;
            end
            // A granted request under redirect returns stale data; mark it for discard.
            if (imem_gnt) begin
               state_d  = WAIT;
               squash_d = redirect;
            end
         end

         WAIT: begin
            if (redirect) begin
               pc_d          = next_pc;
               instr_valid_d = 1'b0;
            end
            if (imem_rvalid) begin
               if (squash_q || redirect) begin
                  squash_d = 1'b0;
                  state_d  = REQ;
               end else begin
                  instr_d       = imem_rdata;
                  instr_pc_d    = pc_q;
                  instr_valid_d = 1'b1;
                  pc_d          = next_pc;
                  state_d       = OUT;
               end
            end else if (redirect) begin
               squash_d = 1'b1;
            end
         end

         OUT: begin
            if (redirect) begin
               pc_d          = next_pc;
               instr_valid_d = 1'b0;
               state_d       = REQ;
            end else if (instr_valid_q && instr_ready) begin
               instr_valid_d = 1'b0;
               state_d       = REQ;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign pc          = pc_q;
   assign imem_addr   = pc_q;
   assign imem_req    = (state_q == REQ);
   assign instr_valid = instr_valid_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;

endmodule
